lc3_decode: RTL and testbench
=============================

Name: lc3_decode

Overview:
- Receiving end of the decode_in interface: the LC-3 decode stage that the decode_in driver feeds.
- Captures npc_in and instr_dout when enable_decode is high.
- Registers IR and NPC, and generates the execute, writeback and memory control words for downstream stages.
- Also flags unsupported opcodes and counts decoded instructions for coverage/debug.

Parameters:
- COUNT_W, 16, width of the decoded-instruction counter (wraps).

Ports:
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable_decode  in  1  capture/decode strobe
- npc_in  in  16  next PC associated with the instruction
- instr_dout  in  16  instruction word from fetch/memory
- IR  out  16  registered instruction
- npc_out  out  16  registered npc_in
- E_Control  out  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
- W_Control  out  2  writeback select
- Mem_Control  out  1  indirect memory access
- decode_valid  out  1  outputs updated on the previous edge
- illegal_instr  out  1  last decoded opcode unsupported
- decode_count  out  COUNT_W  number of decodes since reset

Behaviour:
- Reset:
  - Synchronous, active-high, priority over enable_decode.
  - At the reset edge all outputs become 0: IR, npc_out, E_Control, W_Control, Mem_Control, decode_valid, illegal_instr, decode_count.
- enable_decode=1 at a rising edge:
  - IR<=instr_dout, npc_out<=npc_in.
  - All controls update from instr_dout, not the old IR.
  - decode_valid<=1.
  - decode_count<=decode_count+1, wrapping modulo 2^COUNT_W.
  - Latency: one cycle from inputs to outputs.
- enable_decode=0: IR, npc_out, controls, illegal_instr and decode_count hold; decode_valid<=0.
- Opcode is instr_dout[15:12].
- alu_control, E_Control[5:4]:
  - ADD(0001)=00, AND(0101)=01, NOT(1001)=10; all other opcodes 00.
- pcselect1, E_Control[3:2]:
  - 01 (offset9): BR(0000), LD(0010), LDI(1010), LEA(1110), ST(0011), STI(1011).
  - 10 (offset6): LDR(0110), STR(0111).
  - 11 (zero): JMP(1100).
  - 00 otherwise.
- pcselect2, E_Control[1]: 1 (NPC base) for BR, LD, LDI, LEA, ST, STI; 0 otherwise (JMP/LDR/STR use a register base).
- op2select, E_Control[0]:
  - ADD/AND: equals ~instr_dout[5] (1 = register operand, 0 = imm5).
  - NOT: 1.
  - All other opcodes: 0.
- W_Control:
  - 00 (ALU) for ADD, AND, NOT.
  - 01 (PC/LEA) for LEA.
  - 10 (memory) for LD, LDR, LDI.
  - 00 otherwise.
- Mem_Control: 1 for LDI, STI; else 0.
- Unsupported opcodes 0100, 1000, 1101, 1111:
  - E_Control=0, W_Control=0, Mem_Control=0, illegal_instr<=1.
  - IR and npc_out still capture.
  - Any supported decode clears illegal_instr.
- Back-to-back enables: every cycle decodes a new instruction; there is no bubble.
- Reset asserted in the same cycle as enable_decode: reset wins, capture is discarded, counter 0.
- Unknown inputs are not sanitised; the bench drives known values only.

Decomposition:
- lc3_pkg (shared package) holds:
  - opcode enum;
  - W_Control encodings (WB_ALU, WB_PC, WB_MEM);
  - pcselect1 encodings;
  - alu_control encodings;
  - E_Control field bit positions.
- One sub-module: lc3_decode_ctrl, purely combinational. It maps a 16-bit instruction to {E_Control, W_Control, Mem_Control, illegal}.
- lc3_decode owns all registers and the counter.

Test Plan:
- Reset, then hold reset 2 cycles with enable_decode=1, instr 16'h1283 -> all outputs 0, decode_count=0 throughout.
- enable=1, instr_dout=16'h1283 (ADD R1,R2,R3), npc_in=16'h3001 -> next cycle: IR=16'h1283, npc_out=16'h3001, E_Control=6'h01, W_Control=2'b00, Mem_Control=0, decode_valid=1, decode_count=1.
- Back-to-back decodes, one per cycle:
  - 16'h6A42 (LDR) -> E=6'h08, W=10, Mem=0.
  - 16'hA5FF (LDI) -> E=6'h06, W=10, Mem=1.
  - 16'hE1FE (LEA) -> E=6'h06, W=01.
  - decode_count increments each cycle.
- Decode 16'h5025 (AND imm), then enable=0 for 3 cycles with changing inputs:
  - Decode cycle -> E=6'h10.
  - Following cycles -> outputs hold, decode_valid=0 after the first idle edge.
- Decode 16'hD000 (illegal) -> controls 0, illegal_instr=1, IR=16'hD000. Then decode 16'hC1C0 (JMP) -> E=6'h0C, illegal_instr=0.
- With COUNT_W=4, 16 decodes -> decode_count wraps to 0. Then assert reset mid-stream with enable high -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 decode definitions: opcode enum, control-field encodings and
// the bit positions of the fields packed into E_Control.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    // Writeback source select (W_Control)
    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_PC  = 2'b01,
        WB_MEM = 2'b10
    } wb_sel_e;

    // Address adder operand 1 (pcselect1)
    typedef enum logic [1:0] {
        PC1_NONE = 2'b00,
        PC1_OFF9 = 2'b01,
        PC1_OFF6 = 2'b10,
        PC1_ZERO = 2'b11
    } pcsel1_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_NOT = 2'b10
    } alu_ctl_e;

    // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
    localparam int unsigned E_ALU_HI = 5;
    localparam int unsigned E_ALU_LO = 4;
    localparam int unsigned E_PC1_HI = 3;
    localparam int unsigned E_PC1_LO = 2;
    localparam int unsigned E_PC2    = 1;
    localparam int unsigned E_OP2    = 0;

endpackage

// File: rtl/lc3_decode_ctrl.sv
// Combinational LC-3 control decoder.
// Ports:
//   instr       in  16  instruction word
//   e_control   out 6   {alu_control, pcselect1, pcselect2, op2select}
//   w_control   out 2   writeback select
//   mem_control out 1   indirect memory access (LDI/STI)
//   illegal     out 1   opcode not supported by this pipeline
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  logic [15:0] instr,
    output logic [5:0]  e_control,
    output logic [1:0]  w_control,
    output logic        mem_control,
    output logic        illegal
);

    opcode_e  op;
    alu_ctl_e alu;
    pcsel1_e  pc1;
    logic     pc2;
    logic     op2;
    wb_sel_e  wb;

    // Only the opcode and the imm/register mode bit steer control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[11:6], instr[4:0]};

    assign op = opcode_e'(instr[15:12]);

    always_comb begin
        alu         = ALU_ADD;
        pc1         = PC1_NONE;
        pc2         = 1'b0;
        op2         = 1'b0;
        wb          = WB_ALU;
        mem_control = 1'b0;
        illegal     = 1'b0;
        case (op)
            OP_ADD: begin
                alu = ALU_ADD;
                op2 = ~instr[5];
            end
            OP_AND: begin
                alu = ALU_AND;
                op2 = ~instr[5];
            end
            OP_NOT: begin
                alu = ALU_NOT;
                op2 = 1'b1;
            end
            OP_BR, OP_ST: begin
                pc1 = PC1_OFF9;
                pc2 = 1'b1;
            end
            OP_LD: begin
                pc1 = PC1_OFF9;
                pc2 = 1'b1;
                wb  = WB_MEM;
            end
            OP_LDI: begin
                pc1         = PC1_OFF9;
                pc2         = 1'b1;
                wb          = WB_MEM;
                mem_control = 1'b1;
            end
            OP_STI: begin
                pc1         = PC1_OFF9;
                pc2         = 1'b1;
                mem_control = 1'b1;
            end
            OP_LEA: begin
                pc1 = PC1_OFF9;
                pc2 = 1'b1;
                wb  = WB_PC;
            end
            OP_LDR: begin
                pc1 = PC1_OFF6;
                wb  = WB_MEM;
            end
            OP_STR: begin
                pc1 = PC1_OFF6;
            end
            OP_JMP: begin
                pc1 = PC1_ZERO;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        e_control                    = '0;
        e_control[E_ALU_HI:E_ALU_LO] = alu;
        e_control[E_PC1_HI:E_PC1_LO] = pc1;
        e_control[E_PC2]             = pc2;
        e_control[E_OP2]             = op2;
        w_control                    = wb;
    end

endmodule

// File: rtl/lc3_decode.sv
// LC-3 decode stage: captures instruction/NPC on enable_decode and registers
// the execute, writeback and memory control words, an illegal-opcode flag
// and a wrapping count of decodes.
// Ports:
//   clock, reset (sync, active-high), enable_decode, npc_in[15:0],
//   instr_dout[15:0] -> IR, npc_out, E_Control[5:0], W_Control[1:0],
//   Mem_Control, decode_valid, illegal_instr, decode_count[COUNT_W-1:0]
module lc3_decode
    import lc3_pkg::*;
#(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable_decode,
    input  logic [15:0]        npc_in,
    input  logic [15:0]        instr_dout,
    output logic [15:0]        IR,
    output logic [15:0]        npc_out,
    output logic [5:0]         E_Control,
    output logic [1:0]         W_Control,
    output logic               Mem_Control,
    output logic               decode_valid,
    output logic               illegal_instr,
    output logic [COUNT_W-1:0] decode_count
);

    logic [5:0] e_next;
    logic [1:0] w_next;
    logic       mem_next;
    logic       ill_next;

    // Controls are decoded from the incoming word, not the held IR.
    lc3_decode_ctrl u_ctrl (
        .instr       (instr_dout),
        .e_control   (e_next),
        .w_control   (w_next),
        .mem_control (mem_next),
        .illegal     (ill_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            IR            <= '0;
            npc_out       <= '0;
            E_Control     <= '0;
            W_Control     <= '0;
            Mem_Control   <= 1'b0;
            decode_valid  <= 1'b0;
            illegal_instr <= 1'b0;
            decode_count  <= '0;
        end else if (enable_decode) begin
            IR            <= instr_dout;
            npc_out       <= npc_in;
            E_Control     <= e_next;
            W_Control     <= w_next;
            Mem_Control   <= mem_next;
            decode_valid  <= 1'b1;
            illegal_instr <= ill_next;
            decode_count  <= decode_count + 1'b1;
        end else begin
            decode_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lc3_decode.sv
// Self-checking bench for lc3_decode: a default-width instance and a
// COUNT_W=4 instance share stimulus; expected state is queued per step.
module tb_lc3_decode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_decode = 1'b0;
    logic [15:0] npc_in = '0;
    logic [15:0] instr_dout = '0;

    logic [15:0] IR, npc_out, IR4, npc4;
    logic [5:0]  E_Control, E4;
    logic [1:0]  W_Control, W4;
    logic        Mem_Control, decode_valid, illegal_instr;
    logic        M4, V4, I4;
    logic [15:0] decode_count;
    logic [3:0]  count4;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned fail_cnt = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        m;
        logic        v;
        logic        ill;
        logic [15:0] cnt;
    } exp_t;

    exp_t model;
    exp_t sb[$];

    always #5 clock = ~clock;

    lc3_decode dut (
        .clock(clock), .reset(reset), .enable_decode(enable_decode),
        .npc_in(npc_in), .instr_dout(instr_dout),
        .IR(IR), .npc_out(npc_out), .E_Control(E_Control),
        .W_Control(W_Control), .Mem_Control(Mem_Control),
        .decode_valid(decode_valid), .illegal_instr(illegal_instr),
        .decode_count(decode_count)
    );

    lc3_decode #(.COUNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .enable_decode(enable_decode),
        .npc_in(npc_in), .instr_dout(instr_dout),
        .IR(IR4), .npc_out(npc4), .E_Control(E4),
        .W_Control(W4), .Mem_Control(M4),
        .decode_valid(V4), .illegal_instr(I4),
        .decode_count(count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode table: {E, W, Mem, illegal}
    function automatic logic [9:0] ref_ctrl(input logic [15:0] ins);
        logic [5:0] e;
        logic [1:0] w;
        logic       m;
        logic       il;
        e = 6'h00; w = 2'b00; m = 1'b0; il = 1'b0;
        case (ins[15:12])
            4'b0001: e = {5'b00000, ~ins[5]};
            4'b0101: e = {5'b01000, ~ins[5]};
            4'b1001: e = 6'b100001;
            4'b0000: e = 6'b000110;
            4'b0011: e = 6'b000110;
            4'b0010: begin e = 6'b000110; w = 2'b10; end
            4'b1010: begin e = 6'b000110; w = 2'b10; m = 1'b1; end
            4'b1011: begin e = 6'b000110; m = 1'b1; end
            4'b1110: begin e = 6'b000110; w = 2'b01; end
            4'b0110: begin e = 6'b001000; w = 2'b10; end
            4'b0111: e = 6'b001000;
            4'b1100: e = 6'b001100;
            default: il = 1'b1;
        endcase
        return {e, w, m, il};
    endfunction

    task automatic step(input logic r, input logic en, input logic [15:0] ins, input logic [15:0] npc);
        logic [9:0] c;
        exp_t x;
        reset = r; enable_decode = en; instr_dout = ins; npc_in = npc;
        if (r) begin
            model = '{16'h0, 16'h0, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0, 16'h0};
        end else if (en) begin
            c = ref_ctrl(ins);
            model.ir = ins; model.npc = npc;
            model.e = c[9:4]; model.w = c[3:2]; model.m = c[1]; model.ill = c[0];
            model.v = 1'b1; model.cnt = model.cnt + 16'd1;
        end else begin
            model.v = 1'b0;
        end
        sb.push_back(model);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk("IR", IR, x.ir);
            chk("npc_out", npc_out, x.npc);
            chk("E_Control", E_Control, x.e);
            chk("W_Control", W_Control, x.w);
            chk("Mem_Control", Mem_Control, x.m);
            chk("decode_valid", decode_valid, x.v);
            chk("illegal_instr", illegal_instr, x.ill);
            chk("decode_count", decode_count, x.cnt);
            chk("count4", count4, x.cnt[3:0]);
            chk("E4", E4, x.e);
        end
    endtask

    initial begin
        model = '{16'h0, 16'h0, 6'h0, 2'h0, 1'b0, 1'b0, 1'b0, 16'h0};
        @(negedge clock);

        // Reset held with enable high: reset wins
        step(1, 1, 16'h1283, 16'h3001);
        step(1, 1, 16'h1283, 16'h3001);
        step(1, 1, 16'h1283, 16'h3001);
        chk("rst_count", decode_count, 0);

        step(0, 1, 16'h1283, 16'h3001);
        chk("add_E", E_Control, 6'h01);
        chk("add_IR", IR, 16'h1283);
        chk("add_cnt", decode_count, 1);

        step(0, 1, 16'h6A42, 16'h3002);
        chk("ldr_E", E_Control, 6'h08);
        chk("ldr_W", W_Control, 2'b10);
        step(0, 1, 16'hA5FF, 16'h3003);
        chk("ldi_E", E_Control, 6'h06);
        chk("ldi_M", Mem_Control, 1'b1);
        step(0, 1, 16'hE1FE, 16'h3004);
        chk("lea_W", W_Control, 2'b01);
        chk("b2b_cnt", decode_count, 4);

        step(0, 1, 16'h5025, 16'h3005);
        chk("and_E", E_Control, 6'h10);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 16'($urandom), 16'($urandom));
            chk("hold_E", E_Control, 6'h10);
            chk("hold_valid", decode_valid, 1'b0);
        end

        step(0, 1, 16'hD000, 16'h3006);
        chk("ill_flag", illegal_instr, 1'b1);
        chk("ill_E", E_Control, 6'h00);
        chk("ill_IR", IR, 16'hD000);
        step(0, 1, 16'hC1C0, 16'h3007);
        chk("jmp_E", E_Control, 6'h0C);
        chk("jmp_ill", illegal_instr, 1'b0);

        // Sweep every opcode, including the remaining illegal ones and NOT
        for (int op = 0; op < 16; op++) begin
            step(0, 1, {4'(op), 12'($urandom)}, 16'($urandom));
        end

        // Wrap of the 4-bit counter after 16 decodes from reset
        step(1, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 16'($urandom), 16'($urandom));
        end
        chk("wrap4", count4, 4'd0);
        chk("cnt16_after16", decode_count, 16);

        // Reset mid-stream with enable high
        step(0, 1, 16'h1283, 16'h4000);
        step(1, 1, 16'h5025, 16'h4001);
        chk("midrst_IR", IR, 16'h0);
        chk("midrst_cnt4", count4, 4'd0);
        step(0, 1, 16'h9FFF, 16'h4002);
        chk("not_E", E_Control, 6'h21);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
